// File: rtl/limine2600_timer.sv
// limine2600_timer
// Memory-mapped 32-bit interval timer for the Limine2600 CPU bus.
// A 16-byte register window (CTRL, RELOAD, COUNT, STATUS) is decoded at BASE.
// Every selected access completes with a single-cycle rdy pulse after a
// fixed number of wait states. A prescaled down-counter raises a level
// interrupt when it expires.
module limine2600_timer #(
    parameter logic [31:0] BASE        = 32'hFFFF_0000,
    parameter int          WAIT_STATES = 1,
    parameter int          PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        rdy,
    output logic        irq
);

    // Prescaler width; at least one bit so PRESCALE=1 still has a legal vector.
    localparam int            PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [3:0]    WAIT_LOAD = 4'(WAIT_STATES);

    // Bus FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Register offsets (addr[3:2])
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_RELOAD = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // ------------------------------------------------------------------
    // Bus side
    // ------------------------------------------------------------------
    logic [1:0]  state_reg, state_next;
    logic [3:0]  wait_cnt_reg, wait_cnt_next;
    logic        req_we_reg;
    logic [1:0]  req_off_reg;
    logic [31:0] req_data_reg;
    logic [31:0] data_out_reg, data_out_next;
    logic        rdy_reg;

    logic        sel;
    logic        accept;
    logic        enter_ack;
    logic        acc_we;
    logic [1:0]  acc_off;

    // ------------------------------------------------------------------
    // Timer side
    // ------------------------------------------------------------------
    logic          en_reg, en_next;
    logic          ie_reg, ie_next;
    logic          auto_reg, auto_next;
    logic          pend_reg, pend_next;
    logic          irq_reg;
    logic [31:0]   reload_reg, reload_next;
    logic [31:0]   count_reg, count_next;
    logic [PW-1:0] pre_cnt_reg, pre_cnt_next;
    logic          tick;
    logic          expire;

    // Write commit decode and read view
    logic          wr_commit;
    logic [3:0]    wr_sel;
    logic [31:0]   reg_view [4];
    logic [31:0]   rd_val;

    // Byte-lane bits of the address carry no meaning for word registers.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign sel = cs && (addr[31:4] == BASE[31:4]);

    // With zero wait states the access goes straight from IDLE to ACK, so the
    // read must use the live bus fields rather than the latched request.
    assign acc_we  = (state_reg == ST_IDLE) ? we         : req_we_reg;
    assign acc_off = (state_reg == ST_IDLE) ? addr[3:2] : req_off_reg;

    // Bus FSM next-state: accept, count wait states, abandon on cs drop.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        accept        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (sel) begin
                    accept        = 1'b1;
                    wait_cnt_next = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_next = ST_ACK;
                    end else begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!cs) begin
                    state_next = ST_IDLE;
                end else if (wait_cnt_reg <= 4'd1) begin
                    state_next = ST_ACK;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign enter_ack = (state_next == ST_ACK);

    // Readable view of the register file, indexed by offset.
    assign reg_view[OFF_CTRL]   = {29'd0, auto_reg, ie_reg, en_reg};
    assign reg_view[OFF_RELOAD] = reload_reg;
    assign reg_view[OFF_COUNT]  = count_reg;
    assign reg_view[OFF_STATUS] = {31'd0, pend_reg};
    assign rd_val               = reg_view[acc_off];

    // Read data is captured as ACK is entered and is zero at all other times.
    assign data_out_next = (enter_ack && !acc_we) ? rd_val : 32'd0;

    // Writes take effect on the edge that leaves ACK.
    assign wr_commit = (state_reg == ST_ACK) && req_we_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_commit && (req_off_reg == 2'(gi));
        end
    endgenerate

    // Bus FSM state, request latch and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            req_we_reg   <= 1'b0;
            req_off_reg  <= 2'd0;
            req_data_reg <= 32'd0;
            data_out_reg <= 32'd0;
            rdy_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            data_out_reg <= data_out_next;
            rdy_reg      <= enter_ack;
            if (accept) begin
                req_we_reg   <= we;
                req_off_reg  <= addr[3:2];
                req_data_reg <= data_in;
            end
        end
    end

    // Prescaler tick and counter expiry for the current cycle.
    assign tick   = en_reg && (pre_cnt_reg == PRE_LAST);
    assign expire = tick && (count_reg == 32'd0);

    // Timer next-state; bus writes take priority over hardware updates,
    // except that an expiry always sets PEND.
    always_comb begin
        pre_cnt_next = pre_cnt_reg;
        count_next   = count_reg;
        en_next      = en_reg;
        ie_next      = ie_reg;
        auto_next    = auto_reg;
        reload_next  = reload_reg;
        pend_next    = pend_reg;

        if (!en_reg || tick) begin
            pre_cnt_next = '0;
        end else begin
            pre_cnt_next = pre_cnt_reg + PW'(1);
        end

        if (tick) begin
            if (count_reg == 32'd0) begin
                if (auto_reg) begin
                    count_next = reload_reg;
                end else begin
                    en_next = 1'b0;
                end
            end else begin
                count_next = count_reg - 32'd1;
            end
        end

        if (wr_sel[OFF_CTRL]) begin
            en_next      = req_data_reg[0];
            ie_next      = req_data_reg[1];
            auto_next    = req_data_reg[2];
            pre_cnt_next = '0;
        end
        if (wr_sel[OFF_RELOAD]) begin
            reload_next = req_data_reg;
        end
        if (wr_sel[OFF_COUNT]) begin
            count_next = req_data_reg;
        end

        if (expire) begin
            pend_next = 1'b1;
        end else if (wr_sel[OFF_STATUS] && req_data_reg[0]) begin
            pend_next = 1'b0;
        end
    end

    // Timer registers and the registered interrupt.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_reg      <= 1'b0;
            ie_reg      <= 1'b0;
            auto_reg    <= 1'b0;
            pend_reg    <= 1'b0;
            irq_reg     <= 1'b0;
            reload_reg  <= 32'd0;
            count_reg   <= 32'd0;
            pre_cnt_reg <= '0;
        end else begin
            en_reg      <= en_next;
            ie_reg      <= ie_next;
            auto_reg    <= auto_next;
            pend_reg    <= pend_next;
            irq_reg     <= pend_reg & ie_reg;
            reload_reg  <= reload_next;
            count_reg   <= count_next;
            pre_cnt_reg <= pre_cnt_next;
        end
    end

    assign data_out = data_out_reg;
    assign rdy      = rdy_reg;
    assign irq      = irq_reg;

endmodule
